// File: rtl/tensor_seq_unit.sv
// Sequenced NxN tensor unit: streams A/B in from data memory, runs a one-product-per-cycle
// MAC to form C = A*B (optionally accumulating), and streams C back out under start/busy/done.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; captures op, accumulate and base_addr
// S_LOAD  | one element per cycle from DM into A or B (N*N cycles)
// S_MAC   | one product per cycle into C, l fastest (N*N*N cycles)
// S_STORE | one element per cycle from C out to DM (N*N cycles)
// S_DONE  | single-cycle done pulse, then back to S_IDLE
module tensor_seq_unit #(
  parameter int N      = 3,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              accumulate,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              stall,
  output logic              done
);

  localparam int NN  = N * N;
  localparam int K_W = $clog2(NN);
  localparam int I_W = $clog2(N);

  localparam logic [K_W-1:0] K_LAST = K_W'(NN - 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(N - 1);
  localparam logic [K_W-1:0] N_K    = K_W'(N);

  localparam logic [1:0] OP_LOAD_A = 2'b00;
  localparam logic [1:0] OP_LOAD_B = 2'b01;
  localparam logic [1:0] OP_MATMUL = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_STORE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]        op_r;
  logic              acc_r;
  logic [ADDR_W-1:0] base_r;
  logic [K_W-1:0]    k_cnt;
  logic [I_W-1:0]    i_cnt, j_cnt, l_cnt;
  logic [DATA_W-1:0] a_mat [NN];
  logic [DATA_W-1:0] b_mat [NN];
  logic [DATA_W-1:0] c_mat [NN];
  logic [DATA_W-1:0] sum_r, sum_nxt, prod;
  logic [K_W-1:0]    a_idx, b_idx, c_idx;
  logic              mac_last;

  // Row-major flattening of (i,l), (l,j) and (i,j) into element indices.
  always_comb begin
    a_idx    = K_W'(i_cnt) * N_K + K_W'(l_cnt);
    b_idx    = K_W'(l_cnt) * N_K + K_W'(j_cnt);
    c_idx    = K_W'(i_cnt) * N_K + K_W'(j_cnt);
    prod     = a_mat[a_idx] * b_mat[b_idx];
    sum_nxt  = ((l_cnt == '0) ? '0 : sum_r) + prod;
    mac_last = (i_cnt == I_LAST) && (j_cnt == I_LAST) && (l_cnt == I_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_LOAD_A, OP_LOAD_B: state_nxt = S_LOAD;
            OP_MATMUL:            state_nxt = S_MAC;
            default:              state_nxt = S_STORE;
          endcase
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        mem_addr = base_r + ADDR_W'(k_cnt);
        if (k_cnt == K_LAST) state_nxt = S_DONE;
      end
      S_MAC: begin
        busy     = 1'b1;
        mem_addr = base_r;
        if (mac_last) state_nxt = S_DONE;
      end
      S_STORE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_r + ADDR_W'(k_cnt);
        mem_wdata = c_mat[k_cnt];
        if (k_cnt == K_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r   <= '0;
      acc_r  <= 1'b0;
      base_r <= '0;
      k_cnt  <= '0;
      i_cnt  <= '0;
      j_cnt  <= '0;
      l_cnt  <= '0;
      sum_r  <= '0;
      for (int x = 0; x < NN; x++) begin
        a_mat[x] <= '0;
        b_mat[x] <= '0;
        c_mat[x] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r   <= op;
            acc_r  <= accumulate;
            base_r <= base_addr;
            k_cnt  <= '0;
            i_cnt  <= '0;
            j_cnt  <= '0;
            l_cnt  <= '0;
            sum_r  <= '0;
          end
        end
        S_LOAD: begin
          if (op_r == OP_LOAD_A) a_mat[k_cnt] <= mem_rdata;
          else                   b_mat[k_cnt] <= mem_rdata;
          k_cnt <= k_cnt + 1'b1;
        end
        S_MAC: begin
          sum_r <= sum_nxt;
          if (l_cnt == I_LAST) begin
            c_mat[c_idx] <= (acc_r ? c_mat[c_idx] : '0) + sum_nxt;
            l_cnt        <= '0;
            if (j_cnt == I_LAST) begin
              j_cnt <= '0;
              i_cnt <= i_cnt + 1'b1;
            end else begin
              j_cnt <= j_cnt + 1'b1;
            end
          end else begin
            l_cnt <= l_cnt + 1'b1;
          end
        end
        S_STORE: k_cnt <= k_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_seq_unit.sv
// Directed bench for tensor_seq_unit: a table of ops run back-to-back against a small DM model,
// plus hand-written reset sequences.
module tb_tensor_seq_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        accumulate = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [15:0] mem_rdata;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        busy, stall, done;

  logic        pl_we = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] dm [512];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic        acc;
    logic [8:0]  base;
    int          lat;
    logic [15:0] d0;
    logic [15:0] dstep;
    int          poke;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  assign mem_rdata = dm[mem_addr];

  always @(posedge clk) begin
    if (mem_we)     dm[mem_addr] <= mem_wdata;
    else if (pl_we) dm[pl_addr]  <= pl_data;
  end

  tensor_seq_unit #(.N(3), .DATA_W(16), .ADDR_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .accumulate (accumulate),
    .base_addr  (base_addr),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .stall      (stall),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic a, input logic [8:0] b,
                              input int l, input logic [15:0] d0, input logic [15:0] ds,
                              input int p);
    vec_t v;
    v.op = o; v.acc = a; v.base = b; v.lat = l; v.d0 = d0; v.dstep = ds; v.poke = p;
    return v;
  endfunction

  // Starts v in the cycle after the current one, checks every busy cycle and the done latency.
  // A nonzero poke raises a stray STORE start on that cycle (the done cycle included).
  task automatic run_op(input int idx, input vec_t v);
    int          c;
    bit          seen;
    logic [15:0] k;
    logic [8:0]  ea;
    logic [15:0] ew;
    @(negedge clk);
    start = 1'b1; op = v.op; accumulate = v.acc; base_addr = v.base;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    seen = 1'b0;
    while (!seen && c <= 100) begin
      if (done) begin
        chk($sformatf("v%0d latency", idx), c, v.lat);
        chk($sformatf("v%0d busy in done", idx), {busy, stall}, 2'b00);
        seen = 1'b1;
        if (c == v.poke) begin start = 1'b1; op = 2'b11; end
      end else begin
        k  = 16'(c - 1);
        ea = (v.op == 2'b10) ? v.base : v.base + k[8:0];
        ew = v.d0 + v.dstep * k;
        chk($sformatf("v%0d c%0d busy", idx, c), {busy, stall}, 2'b11);
        chk($sformatf("v%0d c%0d we", idx, c), mem_we, (v.op == 2'b11));
        chk($sformatf("v%0d c%0d addr", idx, c), mem_addr, ea);
        if (v.op == 2'b11) chk($sformatf("v%0d c%0d wdata", idx, c), mem_wdata, ew);
        start = (c == v.poke);
        if (c == v.poke) op = 2'b11;
        @(negedge clk);
        c++;
      end
    end
    if (!seen) chk($sformatf("v%0d done timeout", idx), 0, 1);
  endtask

  initial begin
    int bad;

    #2 reset = 1'b1;
    #1 chk("reset outputs", {mem_addr, mem_we, mem_wdata, busy, stall, done}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle %0d", i), {busy, stall, done, mem_we}, 0);
    end

    for (int i = 0; i < 9; i++) begin
      @(negedge clk); pl_we = 1'b1; pl_addr = 9'(9'h010 + i); pl_data = 16'(i + 1);
      @(negedge clk); pl_addr = 9'(9'h020 + i); pl_data = (i % 4 == 0) ? 16'd1 : 16'd0;
      @(negedge clk); pl_addr = 9'(9'h060 + i); pl_data = 16'h4000;
    end
    @(negedge clk);
    pl_we = 1'b0;

    tbl[0]  = mk(2'b00, 1'b0, 9'h010, 10, 16'd0, 16'd0, 0);
    tbl[1]  = mk(2'b01, 1'b0, 9'h020, 10, 16'd0, 16'd0, 0);
    tbl[2]  = mk(2'b10, 1'b0, 9'h000, 28, 16'd0, 16'd0, 5);
    tbl[3]  = mk(2'b11, 1'b0, 9'h040, 10, 16'd1, 16'd1, 10);
    tbl[4]  = mk(2'b10, 1'b1, 9'h033, 28, 16'd0, 16'd0, 0);
    tbl[5]  = mk(2'b11, 1'b0, 9'h040, 10, 16'd2, 16'd2, 0);
    tbl[6]  = mk(2'b11, 1'b0, 9'h1FC, 10, 16'd2, 16'd2, 0);
    tbl[7]  = mk(2'b00, 1'b0, 9'h060, 10, 16'd0, 16'd0, 0);
    tbl[8]  = mk(2'b01, 1'b0, 9'h060, 10, 16'd0, 16'd0, 0);
    tbl[9]  = mk(2'b10, 1'b0, 9'h000, 28, 16'd0, 16'd0, 0);
    tbl[10] = mk(2'b11, 1'b0, 9'h080, 10, 16'h0000, 16'h0000, 0);

    for (int i = 0; i < 11; i++) run_op(i, tbl[i]);

    chk("dm 0x040", dm[9'h040], 16'd2);
    chk("dm 0x048", dm[9'h048], 16'd18);
    chk("dm 0x1FF", dm[9'h1FF], 16'd8);
    chk("dm 0x000", dm[9'h000], 16'd10);
    chk("dm 0x084", dm[9'h084], 16'd0);

    // Reset in the middle of an accumulating MATMUL, with C nonzero beforehand.
    run_op(11, mk(2'b00, 1'b0, 9'h010, 10, 16'd0, 16'd0, 0));
    run_op(12, mk(2'b01, 1'b0, 9'h020, 10, 16'd0, 16'd0, 0));
    run_op(13, mk(2'b10, 1'b0, 9'h000, 28, 16'd0, 16'd0, 0));
    @(negedge clk);
    start = 1'b1; op = 2'b10; accumulate = 1'b1; base_addr = 9'h000;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("mac cycle 12 busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1 chk("mid-op reset outputs", {mem_addr, mem_we, mem_wdata, busy, stall, done}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("no done after reset", bad, 0);

    run_op(14, mk(2'b00, 1'b0, 9'h010, 10, 16'd0, 16'd0, 0));
    run_op(15, mk(2'b11, 1'b0, 9'h0A0, 10, 16'd0, 16'd0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tensor_seq_unit.md
Name: tensor_seq_unit

Overview:
Parametrised, sequenced successor to the fixed 3x3 tensor path. Holds NxN operand matrices A and B and result matrix C, and runs one of four tensor ops (LOAD_A, LOAD_B, MATMUL, STORE) against data memory under a start/busy/done handshake.
- Element transfers stream one element per cycle, using an internal element counter.
- MATMUL is a sequential multiply-accumulate (MAC), one product per cycle, rather than a combinational array.
- Sits beside the control unit. `stall` freezes the PC while the op runs; the DM port is muxed in while `busy` is high.

Parameters:
- N, 3, matrix dimension (N >= 2).
- DATA_W, 16, element width (signed two's complement).
- ADDR_W, 9, data memory address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request. Sampled only in IDLE.
- op  input  2  operation select: 00 LOAD_A, 01 LOAD_B, 10 MATMUL, 11 STORE. Captured with start.
- accumulate  input  1  MATMUL only. 1 = C += A*B; 0 = C = A*B. Captured with start.
- base_addr  input  ADDR_W  DM address of element 0. Captured with start.
- mem_rdata  input  DATA_W  DM read data. Combinational: valid in the same cycle as mem_addr.
- mem_addr  output  ADDR_W  DM address.
- mem_we  output  1  DM write strobe.
- mem_wdata  output  DATA_W  DM write data.
- busy  output  1  op in progress.
- stall  output  1  equals busy. Holds the PC.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state, including mid-op):
  - Forces IDLE.
  - Clears A, B, C, the counters and the captured op fields.
  - mem_addr=0, mem_we=0, mem_wdata=0, busy=0, stall=0, done=0.
- Element index k runs 0..N*N-1, row-major: k = row*N + col.
- Memory address is base_addr + k, truncated to ADDR_W, so it wraps modulo 2^ADDR_W.
- FSM states: IDLE, LOAD, MAC, STORE, DONE.
- IDLE:
  - start=1 at a rising edge captures op, accumulate and base_addr.
  - Transitions: LOAD_A/LOAD_B go to LOAD; MATMUL goes to MAC; STORE goes to STORE.
  - busy rises in the cycle after the start edge.
  - start is ignored in every state other than IDLE, including DONE.
- LOAD:
  - Lasts N*N cycles.
  - Cycle k: mem_addr = base_addr+k, mem_we=0. At the clock edge, mem_rdata is written into A[k] (LOAD_A) or B[k] (LOAD_B).
  - After k = N*N-1, go to DONE.
- MAC:
  - Lasts N*N*N cycles, with nested counters i (row), j (col), l (inner), l fastest.
  - Each cycle: sum += A[i][l]*B[l][j]. The product and the sum are truncated to DATA_W.
  - sum resets to 0 when l=0.
  - At l=N-1: C[i][j] <= (accumulate ? C[i][j] : 0) + final sum, truncated to DATA_W.
  - A and B are unchanged.
  - mem_we=0; mem_addr holds base_addr.
  - After the last (i,j,l), go to DONE.
- STORE:
  - Lasts N*N cycles.
  - Cycle k: mem_addr = base_addr+k, mem_we=1, mem_wdata = C[k].
  - After k = N*N-1, go to DONE. mem_we is 0 outside STORE.
- DONE:
  - Lasts one cycle: done=1, busy=0.
  - Then IDLE.
- Latency from the start edge to the done pulse:
  - LOAD/STORE: N*N+1 cycles.
  - MATMUL: N^3+1 cycles.
  - For N=3: 10 cycles and 28 cycles respectively.
- Back-to-back: a start in the cycle after done is accepted.
- Overflow wraps silently. There are no flags.

Test Plan:
- Reset: assert reset asynchronously between clock edges -> all outputs 0 immediately; busy stays 0 with no start.
- LOAD_A at base 0x010 with DM[0x010..0x018] = 1..9:
  - mem_addr steps 0x010..0x018 over 9 cycles with mem_we=0.
  - done pulses on the 10th cycle.
  - A = 1..9.
- LOAD_B with identity at 0x020, MATMUL accumulate=0, then STORE base 0x040:
  - MATMUL done 28 cycles after start.
  - STORE writes 1..9 to 0x040..0x048.
- Accumulate: repeat MATMUL with accumulate=1, then STORE -> DM[0x040..0x048] = 2,4,...,18.
- Wrap: STORE at base 0x1FC -> addresses 0x1FC..0x1FF, then 0x000..0x004.
- Busy and reset rules:
  - start pulses during MATMUL are ignored.
  - reset at cycle 12 of MATMUL -> IDLE, C = 0, no done pulse.
  - A new LOAD_A after reset runs normally.
- Overflow: with A = B = all 0x4000, MATMUL -> C elements = 0x0000.
